// File: rtl/alu_txn_issuer_if.sv
// rtl/alu_txn_issuer_if.sv - request, ALU pin and response bundle for alu_txn_issuer
interface alu_txn_issuer_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [WIDTH-1:0]       req_opa;
    logic [WIDTH-1:0]       req_opb;
    logic                   req_cin;
    logic                   req_mode;
    logic [CMD_WIDTH-1:0]   req_cmd;
    logic [1:0]             req_inp_valid;

    logic [WIDTH-1:0]       OPA;
    logic [WIDTH-1:0]       OPB;
    logic                   CIN;
    logic                   MODE;
    logic                   CE;
    logic [CMD_WIDTH-1:0]   CMD;
    logic [1:0]             INP_VALID;
    logic [2*WIDTH-1:0]     RES;
    logic                   COUT;
    logic                   OFLOW;
    logic                   G;
    logic                   L;
    logic                   E;
    logic                   ERR;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [2*WIDTH-1:0]     rsp_res;
    logic [5:0]             rsp_flags;

    modport master (
        input  req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd, req_inp_valid,
        output req_ready,
        output OPA, OPB, CIN, MODE, CE, CMD, INP_VALID,
        input  RES, COUT, OFLOW, G, L, E, ERR,
        output rsp_valid, rsp_res, rsp_flags,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd, req_inp_valid,
        input  req_ready,
        input  OPA, OPB, CIN, MODE, CE, CMD, INP_VALID,
        output RES, COUT, OFLOW, G, L, E, ERR,
        input  rsp_valid, rsp_res, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_txn_issuer.sv
// rtl/alu_txn_issuer.sv - single-outstanding ALU transaction initiator; ALU_ISSUE_STATS_EN adds issue/error counters
module alu_txn_issuer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int STD_LAT   = 1,
    parameter int MUL_LAT   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    alu_txn_issuer_if.master  bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_err
`endif
);
    localparam int MAX_LAT = (STD_LAT > MUL_LAT) ? STD_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             no_inp;
    logic             is_mul;
    logic             wait_done;

    assign accept    = bus.req_valid && bus.req_ready;
    assign no_inp    = (bus.req_inp_valid == 2'b00);
    // Latency is chosen from the latched pins, which hold the accepted command during ISSUE.
    assign is_mul    = bus.MODE && ((bus.CMD == CMD_WIDTH'(9)) || (bus.CMD == CMD_WIDTH'(10)));
    assign wait_done = (wait_cnt == '0);

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = no_inp ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = RESP;
            RESP:    if (bus.rsp_valid && bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_res   <= '0;
            bus.rsp_flags <= '0;
            bus.CE        <= 1'b0;
            bus.INP_VALID <= 2'b00;
            bus.OPA       <= '0;
            bus.OPB       <= '0;
            bus.CIN       <= 1'b0;
            bus.MODE      <= 1'b0;
            bus.CMD       <= '0;
            wait_cnt      <= '0;
        end else begin
            bus.req_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (no_inp) begin
                            bus.rsp_res   <= '0;
                            bus.rsp_flags <= 6'b000001;
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            bus.OPA       <= bus.req_opa;
                            bus.OPB       <= bus.req_opb;
                            bus.CIN       <= bus.req_cin;
                            bus.MODE      <= bus.req_mode;
                            bus.CMD       <= bus.req_cmd;
                            bus.INP_VALID <= bus.req_inp_valid;
                            bus.CE        <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(STD_LAT - 1);
                end
                WAIT: begin
                    if (wait_done) begin
                        bus.rsp_res   <= bus.RES;
                        bus.rsp_flags <= {bus.COUT, bus.OFLOW, bus.G, bus.L, bus.E, bus.ERR};
                        bus.rsp_valid <= 1'b1;
                        bus.CE        <= 1'b0;
                        bus.INP_VALID <= 2'b00;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic issue_entry;
    logic err_entry;

    assign issue_entry = (state == IDLE) && accept && !no_inp;
    assign err_entry   = ((state == IDLE) && accept && no_inp) ||
                         ((state == WAIT) && wait_done && bus.ERR);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            stat_issued <= '0;
            stat_err    <= '0;
        end else begin
            if (issue_entry && (stat_issued != 16'hFFFF)) stat_issued <= stat_issued + 16'd1;
            if (err_entry && (stat_err != 16'hFFFF))      stat_err    <= stat_err + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_txn_issuer.sv
// tb/tb_alu_txn_issuer.sv - directed bench for alu_txn_issuer with a latency-aware ALU model
module tb_alu_txn_issuer;
    logic clk = 1'b0;
    logic rstn;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    alu_txn_issuer_if #(.WIDTH(8), .CMD_WIDTH(4)) bus();

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_err;
`endif

    alu_txn_issuer #(.WIDTH(8), .CMD_WIDTH(4), .STD_LAT(1), .MUL_LAT(3)) dut (
        .CLK (clk),
        .RST (rstn),
        .bus (bus)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_err    (stat_err)
`endif
    );

    // ALU model: result is only correct once CE has been high for the command latency.
    int          ce_cnt = 0;
    int          m_lat;
    logic [8:0]  sum9;
    logic [15:0] m_val;
    logic [5:0]  m_flags;
    logic [15:0] o_res;
    logic [5:0]  o_flags;

    always @(posedge clk) ce_cnt <= bus.CE ? ce_cnt + 1 : 0;

    always_comb begin
        m_lat   = (bus.MODE && (bus.CMD == 4'd9 || bus.CMD == 4'd10)) ? 3 : 1;
        sum9    = {1'b0, bus.OPA} + {1'b0, bus.OPB} + {8'h00, bus.CIN};
        m_val   = 16'h0000;
        m_flags = 6'b000000;
        if (bus.MODE) begin
            case (bus.CMD)
                4'd0:    begin m_val = {7'h00, sum9}; m_flags[5] = sum9[8]; end
                4'd8:    begin
                             m_flags[3] = bus.OPA > bus.OPB;
                             m_flags[2] = bus.OPA < bus.OPB;
                             m_flags[1] = bus.OPA == bus.OPB;
                         end
                4'd9:    m_val = {8'h00, bus.OPA} * {8'h00, bus.OPB};
                4'd10:   m_val = {8'h00, bus.OPA} * {8'h00, bus.OPB} + 16'd1;
                default: m_flags[0] = 1'b1;
            endcase
        end else begin
            case (bus.CMD)
                4'd9:    m_val = {8'h00, bus.OPA & bus.OPB};
                default: m_flags[0] = 1'b1;
            endcase
        end
        o_res   = (ce_cnt >= m_lat) ? m_val   : 16'hBAD0;
        o_flags = (ce_cnt >= m_lat) ? m_flags : 6'b111111;
    end

    assign bus.RES   = o_res;
    assign bus.COUT  = o_flags[5];
    assign bus.OFLOW = o_flags[4];
    assign bus.G     = o_flags[3];
    assign bus.L     = o_flags[2];
    assign bus.E     = o_flags[1];
    assign bus.ERR   = o_flags[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic mode, input logic [3:0] cmd,
                           input logic [7:0] opa, input logic [7:0] opb, input logic cin,
                           input logic [1:0] iv, input logic [15:0] exp_res,
                           input logic [5:0] exp_flags, input int exp_ce, input int exp_lat,
                           input int hold);
        int n, cyc, ce_n, pin_bad, hold_bad;
        @(negedge clk);
        bus.req_opa = opa; bus.req_opb = opb; bus.req_cin = cin;
        bus.req_mode = mode; bus.req_cmd = cmd; bus.req_inp_valid = iv;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_opa = ~opa; bus.req_opb = ~opb; bus.req_cmd = ~cmd;
        cyc = 1; ce_n = 0; pin_bad = 0;
        while (!bus.rsp_valid && cyc < 40) begin
            if (bus.CE) begin
                ce_n++;
                if (bus.OPA !== opa || bus.OPB !== opb || bus.CMD !== cmd ||
                    bus.MODE !== mode || bus.CIN !== cin || bus.INP_VALID !== iv)
                    pin_bad++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rsp_cycle"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_ce_cycles"}, 32'(ce_n), 32'(exp_ce));
        check({tag, "_pins_stable"}, 32'(pin_bad), 32'd0);
        check({tag, "_rsp_res"}, 32'(bus.rsp_res), 32'(exp_res));
        check({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'(exp_flags));
        check({tag, "_ce_iv_off"}, {30'd0, bus.CE, |bus.INP_VALID}, 32'd0);
        if (hold > 0) begin
            hold_bad = 0;
            bus.req_inp_valid = 2'b11;
            bus.req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.rsp_res !== exp_res || bus.rsp_flags !== exp_flags ||
                    bus.req_ready || bus.CE)
                    hold_bad++;
            end
            bus.req_valid = 1'b0;
            check({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n_rsp;
        rstn = 1'b0;
        bus.req_valid = 1'b0; bus.req_opa = '0; bus.req_opb = '0; bus.req_cin = 1'b0;
        bus.req_mode = 1'b0; bus.req_cmd = '0; bus.req_inp_valid = 2'b00; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_pins", {bus.OPA, bus.OPB, bus.CMD, bus.INP_VALID, bus.CE, bus.CIN, bus.MODE, 5'd0}, 32'd0);
        check("rst_rsp_data", {bus.rsp_res, 10'd0, bus.rsp_flags}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        run_txn("add",     1'b1, 4'd0,  8'h05, 8'h03, 1'b0, 2'b11, 16'h0008, 6'b000000, 2, 3, 0);
        run_txn("mul9",    1'b1, 4'd9,  8'h04, 8'h03, 1'b0, 2'b11, 16'h000C, 6'b000000, 4, 5, 0);
        run_txn("add_co",  1'b1, 4'd0,  8'hFF, 8'h02, 1'b0, 2'b11, 16'h0101, 6'b100000, 2, 3, 0);
        run_txn("cmp",     1'b1, 4'd8,  8'h07, 8'h09, 1'b0, 2'b11, 16'h0000, 6'b000100, 2, 3, 0);
        run_txn("bp_add",  1'b1, 4'd0,  8'h10, 8'h20, 1'b1, 2'b11, 16'h0031, 6'b000000, 2, 3, 10);

        // Reset while a multiply sits in WAIT.
        @(negedge clk);
        bus.req_opa = 8'h06; bus.req_opb = 8'h07; bus.req_cin = 1'b0;
        bus.req_mode = 1'b1; bus.req_cmd = 4'd9; bus.req_inp_valid = 2'b11; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rstw_ce_before", 32'(bus.CE), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("rstw_ce", 32'(bus.CE), 32'd0);
        check("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstw_pins", {bus.OPA, bus.OPB, bus.CMD, bus.INP_VALID, bus.req_ready, 9'd0}, 32'd0);
        rstn = 1'b1;
        bus.rsp_ready = 1'b1;
        n_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        bus.rsp_ready = 1'b0;
        check("rstw_no_rsp", 32'(n_rsp), 32'd0);
        check("rstw_idle", 32'(bus.req_ready), 32'd1);

        run_txn("mul10",   1'b1, 4'd10, 8'h05, 8'h06, 1'b0, 2'b11, 16'h001F, 6'b000000, 4, 5, 0);
        run_txn("and_l9",  1'b0, 4'd9,  8'hF0, 8'h3C, 1'b0, 2'b11, 16'h0030, 6'b000000, 2, 3, 0);
        run_txn("add2",    1'b1, 4'd0,  8'h21, 8'h12, 1'b0, 2'b10, 16'h0033, 6'b000000, 2, 3, 0);
        run_txn("noinp",   1'b1, 4'd0,  8'h05, 8'h03, 1'b0, 2'b00, 16'h0000, 6'b000001, 0, 1, 0);

`ifdef ALU_ISSUE_STATS_EN
        check("stat_issued", 32'(stat_issued), 32'd3);
        check("stat_err", 32'(stat_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
